// File: rtl/daub6_pkg.sv
// rtl/daub6_pkg.sv - shared Q15 Daubechies-6 coefficients, widths, rounding and serializer state
package daub6_pkg;

  localparam int D6_DATA_WIDTH = 16;
  localparam int D6_FRAC_BITS  = 15;
  localparam int D6_ACC_WIDTH  = 35;

  typedef logic signed [15:0] coef_t;

  // Low-pass (h) and high-pass (g) Q15 taps, identical to the analysis side.
  localparam coef_t H0 =  16'sd1155;
  localparam coef_t H1 = -16'sd2796;
  localparam coef_t H2 = -16'sd4423;
  localparam coef_t H3 =  16'sd15058;
  localparam coef_t H4 =  16'sd26440;
  localparam coef_t H5 =  16'sd10898;

  localparam coef_t G0 =  16'sd10898;
  localparam coef_t G1 = -16'sd26440;
  localparam coef_t G2 =  16'sd15058;
  localparam coef_t G3 =  16'sd4423;
  localparam coef_t G4 = -16'sd2796;
  localparam coef_t G5 = -16'sd1155;

  // Half an LSB of the output scale, added before the rescale shift.
  function automatic int round_const(input int frac_bits);
    return 1 << (frac_bits - 1);
  endfunction

  localparam int D6_ROUND_CONST = round_const(D6_FRAC_BITS);

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_EVEN = 2'd1,
    SER_ODD  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/daub6_poly3_mac.sv
// rtl/daub6_poly3_mac.sv - one synthesis phase: 3 a-taps + 3 d-taps, registered products, rounded sum (DAUB6_SYNTH_SAT_EN selects saturation)
module daub6_poly3_mac
  import daub6_pkg::*;
#(
  parameter int    DATA_WIDTH      = D6_DATA_WIDTH,
  parameter int    FRACTIONAL_BITS = D6_FRAC_BITS,
  parameter int    ACC_WIDTH       = D6_ACC_WIDTH,
  parameter coef_t CA0             = '0,
  parameter coef_t CA1             = '0,
  parameter coef_t CA2             = '0,
  parameter coef_t CD0             = '0,
  parameter coef_t CD1             = '0,
  parameter coef_t CD2             = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adv,
  input  logic signed [DATA_WIDTH-1:0] a0,
  input  logic signed [DATA_WIDTH-1:0] a1,
  input  logic signed [DATA_WIDTH-1:0] a2,
  input  logic signed [DATA_WIDTH-1:0] d0,
  input  logic signed [DATA_WIDTH-1:0] d1,
  input  logic signed [DATA_WIDTH-1:0] d2,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         clip
);

  localparam int PW = DATA_WIDTH + $bits(coef_t);
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(round_const(FRACTIONAL_BITS));

  logic signed [PW-1:0]         prod [6];
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  rnd;
  logic signed [ACC_WIDTH-1:0]  sh;
  logic signed [DATA_WIDTH-1:0] y_next;
  logic                         clip_next;

  // S2: register the six Q30 products when the pipeline advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) prod[i] <= '0;
    end else if (adv) begin
      prod[0] <= PW'(a0) * PW'(CA0);
      prod[1] <= PW'(a1) * PW'(CA1);
      prod[2] <= PW'(a2) * PW'(CA2);
      prod[3] <= PW'(d0) * PW'(CD0);
      prod[4] <= PW'(d1) * PW'(CD1);
      prod[5] <= PW'(d2) * PW'(CD2);
    end
  end

  // Accumulate, add half an LSB, rescale back to Q15
  always_comb begin
    sum = '0;
    for (int i = 0; i < 6; i++) sum = sum + ACC_WIDTH'(prod[i]);
    rnd = sum + RND;
    sh  = rnd >>> FRACTIONAL_BITS;
  end

`ifdef DAUB6_SYNTH_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - 1;

  // Clamp to the signed output range and flag any clipping
  always_comb begin
    y_next    = sh[DATA_WIDTH-1:0];
    clip_next = 1'b0;
    if (sh > SMAX) begin
      y_next    = SMAX[DATA_WIDTH-1:0];
      clip_next = 1'b1;
    end else if (sh < SMIN) begin
      y_next    = SMIN[DATA_WIDTH-1:0];
      clip_next = 1'b1;
    end
  end
`else
  logic unused_sh_hi;
  assign unused_sh_hi = ^sh[ACC_WIDTH-1:DATA_WIDTH];

  // Wrap-around narrowing keeps the low output bits
  always_comb begin
    y_next    = sh[DATA_WIDTH-1:0];
    clip_next = 1'b0;
  end
`endif

  // S3: register the narrowed phase sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      clip <= 1'b0;
    end else if (adv) begin
      y    <= y_next;
      clip <= clip_next;
    end
  end

endmodule

// File: rtl/daub6_synth_fixed.sv
// rtl/daub6_synth_fixed.sv - Q15 Daubechies-6 synthesis stage, a/d pairs in, even/odd samples out (DAUB6_SYNTH_SAT_EN enables saturation)
module daub6_synth_fixed
  import daub6_pkg::*;
#(
  parameter int DATA_WIDTH      = D6_DATA_WIDTH,
  parameter int FRACTIONAL_BITS = D6_FRAC_BITS,
  parameter int ACC_WIDTH       = D6_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_d,
  input  logic                         hist_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_odd,
  output logic                         sat_flag
);

  logic accept, adv, load;
  logic v1, v2, v3;
  logic signed [DATA_WIDTH-1:0] a0_q, a1_q, a2_q, d0_q, d1_q, d2_q;
  logic signed [DATA_WIDTH-1:0] even_y, odd_y, even_buf, odd_buf;
  logic even_clip, odd_clip;
  ser_state_t state, state_nxt;

  // The pipeline moves whenever S3 is empty or its pair is being handed to the buffer.
  assign load     = v3 && ((state == SER_IDLE) || ((state == SER_ODD) && out_ready));
  assign adv      = !v3 || load;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // S1: a/d history shifts on acceptance; a clear drops the older taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q <= '0; a1_q <= '0; a2_q <= '0;
      d0_q <= '0; d1_q <= '0; d2_q <= '0;
    end else if (accept) begin
      a0_q <= in_a;
      d0_q <= in_d;
      a1_q <= hist_clr ? '0 : a0_q;
      a2_q <= hist_clr ? '0 : a1_q;
      d1_q <= hist_clr ? '0 : d0_q;
      d2_q <= hist_clr ? '0 : d1_q;
    end else if (hist_clr) begin
      a0_q <= '0; a1_q <= '0; a2_q <= '0;
      d0_q <= '0; d1_q <= '0; d2_q <= '0;
    end
  end

  // Valid bits travel with the data through S1..S3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  daub6_poly3_mac #(
    .DATA_WIDTH(DATA_WIDTH), .FRACTIONAL_BITS(FRACTIONAL_BITS), .ACC_WIDTH(ACC_WIDTH),
    .CA0(H0), .CA1(H2), .CA2(H4), .CD0(G0), .CD1(G2), .CD2(G4)
  ) u_even (
    .clk(clk), .rst_n(rst_n), .adv(adv),
    .a0(a0_q), .a1(a1_q), .a2(a2_q), .d0(d0_q), .d1(d1_q), .d2(d2_q),
    .y(even_y), .clip(even_clip)
  );

  daub6_poly3_mac #(
    .DATA_WIDTH(DATA_WIDTH), .FRACTIONAL_BITS(FRACTIONAL_BITS), .ACC_WIDTH(ACC_WIDTH),
    .CA0(H1), .CA1(H3), .CA2(H5), .CD0(G1), .CD1(G3), .CD2(G5)
  ) u_odd (
    .clk(clk), .rst_n(rst_n), .adv(adv),
    .a0(a0_q), .a1(a1_q), .a2(a2_q), .d0(d0_q), .d1(d1_q), .d2(d2_q),
    .y(odd_y), .clip(odd_clip)
  );

  // Pair buffer captures both phases so S3 can refill while they drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_buf <= '0;
      odd_buf  <= '0;
    end else if (load) begin
      even_buf <= even_y;
      odd_buf  <= odd_y;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_nxt;
  end

  // Serializer next state and output mux: even beat first, then odd
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_odd   = 1'b0;
    case (state)
      SER_IDLE: begin
        if (load) state_nxt = SER_EVEN;
      end
      SER_EVEN: begin
        out_valid = 1'b1;
        out_data  = even_buf;
        if (out_ready) state_nxt = SER_ODD;
      end
      SER_ODD: begin
        out_valid = 1'b1;
        out_data  = odd_buf;
        out_odd   = 1'b1;
        if (out_ready) state_nxt = load ? SER_EVEN : SER_IDLE;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

`ifdef DAUB6_SYNTH_SAT_EN
  logic even_clip_buf, odd_clip_buf, sat_q;

  // Clip flags follow their samples into the pair buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_clip_buf <= 1'b0;
      odd_clip_buf  <= 1'b0;
    end else if (load) begin
      even_clip_buf <= even_clip;
      odd_clip_buf  <= odd_clip;
    end
  end

  // Sticky flag sets once a clipped sample is on the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_q | ((state == SER_EVEN) && even_clip_buf)
                               | ((state == SER_ODD) && odd_clip_buf);
  end

  assign sat_flag = sat_q;
`else
  logic unused_clip;
  assign unused_clip = even_clip ^ odd_clip;
  assign sat_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_daub6_synth_fixed.sv
// tb/tb_daub6_synth_fixed.sv - directed self-checking bench for daub6_synth_fixed
module tb_daub6_synth_fixed;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic signed [15:0] in_d;
  logic               hist_clr;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_odd;
  logic               sat_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  typedef struct {
    logic signed [15:0] data;
    logic               odd;
    int                 cyc;
  } beat_t;

  beat_t beat_q[$];

  int vec_a[8] = '{1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000};
  int vec_d[8] = '{-500, 1500, -2500, 3500, -4500, 5500, -6500, 7500};

  daub6_synth_fixed dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_d(in_d), .hist_clr(hist_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_odd(out_odd), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) beat_q.push_back('{out_data, out_odd, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int model(input int a0, a1, a2, d0, d1, d2, input bit odd);
    longint s;
    logic signed [15:0] w;
    if (!odd) s = 1155 * longint'(a0) - 4423 * longint'(a1) + 26440 * longint'(a2)
                + 10898 * longint'(d0) + 15058 * longint'(d1) - 2796 * longint'(d2);
    else      s = -2796 * longint'(a0) + 15058 * longint'(a1) + 10898 * longint'(a2)
                - 26440 * longint'(d0) + 4423 * longint'(d1) - 1155 * longint'(d2);
    s = (s + 16384) >>> 15;
`ifdef DAUB6_SYNTH_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    w = s[15:0];
    return int'(w);
  endfunction

  task automatic send_pair(input int a, input int d, input logic clr, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_a = 16'(a);
    in_d = 16'(d);
    hist_clr = clr;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      checks++; errors++;
      $display("FAIL send_pair timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    in_valid = 1'b0;
    hist_clr = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int t = 0;
    while (beat_q.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (beat_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s beat count: got %0d required %0d", name, beat_q.size(), n);
    end
  endtask

  task automatic flush();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    beat_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_d = '0; hist_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset out_data: got %0d required 0", out_data); end
    checks++; if (out_odd !== 1'b0) begin errors++; $display("FAIL reset out_odd: got %0b required 0", out_odd); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset sat_flag: got %0b required 0", sat_flag); end
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string name, input int exp[], input int n);
    logic signed [15:0] e;
    logic eo;
    for (int i = 0; i < n; i++) begin
      if (i < beat_q.size()) begin
        e = 16'(exp[i]);
        eo = 1'(i % 2);
        checks++;
        if (beat_q[i].data !== e) begin
          errors++; $display("FAIL %s data[%0d]: got %0d required %0d", name, i, beat_q[i].data, e);
        end
        checks++;
        if (beat_q[i].odd !== eo) begin
          errors++; $display("FAIL %s odd[%0d]: got %0b required %0b", name, i, beat_q[i].odd, eo);
        end
      end
    end
  endtask

  task automatic test_impulse_a();
    int w, acc;
    int exp[] = '{-1155, 2796, 4423, -15058, -26440, -10898, 0, 0};
    flush();
    send_pair(-32768, 0, 1'b0, w);
    acc = last_acc_cyc;
    for (int k = 0; k < 4; k++) send_pair(0, 0, 1'b0, w);
    wait_beats(8, "impulse_a");
    check_seq("impulse_a", exp, 8);
    if (beat_q.size() > 0) begin
      checks++;
      if (beat_q[0].cyc !== acc + 3) begin
        errors++; $display("FAIL latency: first beat cycle %0d required %0d", beat_q[0].cyc, acc + 3);
      end
    end
  endtask

  task automatic test_impulse_d();
    int w;
    int exp[] = '{-10898, 26440, -15058, -4423, 2796, 1155, 0, 0};
    flush();
    send_pair(0, -32768, 1'b0, w);
    for (int k = 0; k < 4; k++) send_pair(0, 0, 1'b0, w);
    wait_beats(8, "impulse_d");
    check_seq("impulse_d", exp, 8);
  endtask

  task automatic test_overflow();
    int w;
    logic signed [15:0] e_even;
    logic e_sat;
`ifdef DAUB6_SYNTH_SAT_EN
    e_even = -16'sd32768;
    e_sat = 1'b1;
`else
    e_even = 16'sd19204;
    e_sat = 1'b0;
`endif
    flush();
    for (int k = 0; k < 4; k++) send_pair(-32768, -32768, 1'b0, w);
    wait_beats(8, "overflow");
    if (beat_q.size() >= 8) begin
      for (int i = 4; i < 8; i += 2) begin
        checks++;
        if (beat_q[i].data !== e_even) begin errors++; $display("FAIL overflow even[%0d]: got %0d required %0d", i, beat_q[i].data, e_even); end
        checks++;
        if (beat_q[i+1].data !== 16'sd12) begin errors++; $display("FAIL overflow odd[%0d]: got %0d required 12", i + 1, beat_q[i+1].data); end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sat_flag !== e_sat) begin errors++; $display("FAIL overflow sat_flag: got %0b required %0b", sat_flag, e_sat); end
  endtask

  task automatic check_model(input string name);
    int pa1, pa2, pd1, pd2, e;
    logic signed [15:0] es;
    for (int k = 0; k < 8; k++) begin
      pa1 = (k >= 1) ? vec_a[k-1] : 0;
      pa2 = (k >= 2) ? vec_a[k-2] : 0;
      pd1 = (k >= 1) ? vec_d[k-1] : 0;
      pd2 = (k >= 2) ? vec_d[k-2] : 0;
      for (int p = 0; p < 2; p++) begin
        if (2 * k + p < beat_q.size()) begin
          e = model(vec_a[k], pa1, pa2, vec_d[k], pd1, pd2, p[0]);
          es = 16'(e);
          checks++;
          if (beat_q[2*k+p].data !== es || beat_q[2*k+p].odd !== p[0]) begin
            errors++;
            $display("FAIL %s beat[%0d]: got %0d/odd=%0b required %0d/odd=%0b", name, 2 * k + p,
                     beat_q[2*k+p].data, beat_q[2*k+p].odd, es, p[0]);
          end
        end
      end
    end
  endtask

  task automatic test_throughput();
    int w, ew;
    flush();
    for (int k = 0; k < 8; k++) begin
      send_pair(vec_a[k], vec_d[k], 1'b0, w);
      ew = (k < 4) ? 0 : 1;
      checks++;
      if (w !== ew) begin errors++; $display("FAIL throughput in_ready wait pair %0d: got %0d required %0d", k, w, ew); end
    end
    wait_beats(16, "throughput");
    check_model("throughput");
    if (beat_q.size() >= 16) begin
      checks++;
      if (beat_q[15].cyc !== beat_q[0].cyc + 15) begin
        errors++; $display("FAIL throughput out_valid gap: span %0d required 15", beat_q[15].cyc - beat_q[0].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic signed [15:0] held_d;
    logic held_o;
    flush();
    fork
      begin
        for (int k = 0; k < 8; k++) send_pair(vec_a[k], vec_d[k], 1'b0, w);
      end
      begin
        int t = 0;
        while (beat_q.size() < 6 && t < 200) begin
          @(posedge clk); #1;
          t++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        held_d = out_data;
        held_o = out_odd;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (out_data !== held_d || out_odd !== held_o) begin
            errors++; $display("FAIL backpressure hold: got %0d/%0b required %0d/%0b", out_data, out_odd, held_d, held_o);
          end
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure stall: in_ready=%0b out_valid=%0b required 0/1", in_ready, out_valid);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_beats(16, "backpressure");
    check_model("backpressure");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (beat_q.size() !== 16) begin errors++; $display("FAIL backpressure beat total: got %0d required 16", beat_q.size()); end
  endtask

  task automatic test_hist_clr();
    int w;
    int exp[] = '{-1155, 2796, -1155, 2796, 4423, -15058, -26440, -10898, 0, 0, 0, 0};
    flush();
    send_pair(-32768, 0, 1'b0, w);
    send_pair(-32768, 0, 1'b1, w);
    for (int k = 0; k < 4; k++) send_pair(0, 0, 1'b0, w);
    wait_beats(12, "hist_clr");
    check_seq("hist_clr", exp, 12);
  endtask

  task automatic test_reset_mid();
    int w;
    int exp[] = '{-1155, 2796, 4423, -15058};
    flush();
    send_pair(-32768, 0, 1'b0, w);
    send_pair(1000, 2000, 1'b0, w);
    send_pair(3000, -4000, 1'b0, w);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_mid precondition out_valid: got %0b required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid async: got %0b required 0", out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || sat_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid release: in_ready=%0b sat_flag=%0b out_valid=%0b required 1/0/0", in_ready, sat_flag, out_valid);
    end
    beat_q.delete();
    send_pair(-32768, 0, 1'b0, w);
    send_pair(0, 0, 1'b0, w);
    wait_beats(4, "reset_mid");
    check_seq("reset_mid", exp, 4);
  endtask

  initial begin
    test_reset();
    test_impulse_a();
    test_impulse_d();
    test_overflow();
    test_throughput();
    test_backpressure();
    test_hist_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
